// File: rtl/tran_pkg.sv
// rtl/tran_pkg.sv - shared widths, FSM state and row counter types for the 4x4 forward transform
package tran_pkg;

  // Residual sample width minus one
  localparam int BIT_LENGTH = 15;

  // Residual, intermediate (after row pass) and coefficient widths
  localparam int IN_W  = BIT_LENGTH + 1;
  localparam int MID_W = BIT_LENGTH + 4;
  localparam int OUT_W = BIT_LENGTH + 7;

  // LOAD collects four residual rows, DRAIN emits four coefficient rows
  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Row index within a 4x4 block
  typedef logic [1:0] row_cnt_t;

endpackage

// File: rtl/fwdtran_butterfly4.sv
// rtl/fwdtran_butterfly4.sv - combinational 4-point forward core-transform butterfly
module fwdtran_butterfly4 #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] x [4],
  output logic signed [W+2:0] y [4]
);

  // Operands widened up front so every sum and shift is exact (gain at most 6)
  logic signed [W+2:0] e [4];
  logic signed [W+2:0] s0, s1, d0, d1;

  // Even/odd split followed by the [1,1,1,1] [2,1,-1,-2] [1,-1,-1,1] [1,-2,2,-1] combine
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      e[i] = {{3{x[i][W-1]}}, x[i]};
    end
    s0   = e[0] + e[3];
    s1   = e[1] + e[2];
    d0   = e[0] - e[3];
    d1   = e[1] - e[2];
    y[0] = s0 + s1;
    y[1] = (d0 <<< 1) + d1;
    y[2] = s0 - s1;
    y[3] = d0 - (d1 <<< 1);
  end

endmodule

// File: rtl/fwdtran_4x4.sv
// rtl/fwdtran_4x4.sv - streaming forward 4x4 integer transform, one row per handshake in and out
module fwdtran_4x4 #(
  parameter int  BIT_LENGTH = tran_pkg::BIT_LENGTH,
  localparam int IN_W       = BIT_LENGTH + 1,
  localparam int MID_W      = BIT_LENGTH + 4,
  localparam int OUT_W      = BIT_LENGTH + 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_row [4],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_row [4]
);

  import tran_pkg::state_t;
  import tran_pkg::row_cnt_t;
  import tran_pkg::LOAD;
  import tran_pkg::DRAIN;

  state_t   state_q, state_d;
  row_cnt_t row_cnt_q, row_cnt_d;

  // Row-transformed block; stays frozen for the whole drain phase
  logic signed [MID_W-1:0] h_q   [4][4];
  logic signed [MID_W-1:0] h_row [4];

  logic in_fire;
  logic out_fire;

  // Horizontal pass on the incoming residual row
  fwdtran_butterfly4 #(.W(IN_W)) u_row_bfly (
    .x (in_row),
    .y (h_row)
  );

  // Handshake flags come from registered state only
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Next-state and row counter: count four accepts, then four output transfers
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    case (state_q)
      LOAD: begin
        if (in_fire) begin
          row_cnt_d = row_cnt_q + 2'd1;
          if (row_cnt_q == 2'd3) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_fire) begin
          row_cnt_d = row_cnt_q + 2'd1;
          if (row_cnt_q == 2'd3) begin
            state_d = LOAD;
          end
        end
      end
      default: begin
        state_d   = LOAD;
        row_cnt_d = '0;
      end
    endcase
  end

  // State and row counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD;
      row_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
    end
  end

  // Capture each row-transformed input into the intermediate buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q <= '{default: '0};
    end else if (in_fire) begin
      h_q[row_cnt_q] <= h_row;
    end
  end

  // Vertical pass: one butterfly per column, output row picked by row_cnt
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic signed [MID_W-1:0] col_x [4];
    logic signed [OUT_W-1:0] col_y [4];

    // Gather column c of the buffered block
    always_comb begin
      for (int r = 0; r < 4; r++) begin
        col_x[r] = h_q[r][c];
      end
    end

    fwdtran_butterfly4 #(.W(MID_W)) u_col_bfly (
      .x (col_x),
      .y (col_y)
    );

    assign out_row[c] = col_y[row_cnt_q];
  end

endmodule

// File: tb/tb_fwdtran_4x4.sv
// tb/tb_fwdtran_4x4.sv - scoreboard bench for the streaming forward 4x4 transform
module tb_fwdtran_4x4;

  localparam int OW = 22;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic signed [15:0] in_row [4];
  logic out_valid;
  logic out_ready;
  logic signed [OW-1:0] out_row [4];

  int n_chk  = 0;
  int n_fail = 0;
  int rows_seen = 0;
  bit rnd_ready = 1'b0;

  logic [4*OW-1:0] exp_q [$];
  logic            held_v = 1'b0;
  logic [4*OW-1:0] held;

  fwdtran_4x4 dut (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 90000 cycles");
    $fatal(1);
  end

  function automatic logic [4*OW-1:0] act_row();
    return {out_row[3], out_row[2], out_row[1], out_row[0]};
  endfunction

  task automatic check(input string name, input logic [4*OW-1:0] act, input logic [4*OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int e [4][4]);
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back({22'(e[r][3]), 22'(e[r][2]), 22'(e[r][1]), 22'(e[r][0])});
    end
  endtask

  // Plain matrix product Cf * X * Cf^T
  task automatic model(input int x [4][4], output int y [4][4]);
    int cf [4][4];
    cf = '{'{1, 1, 1, 1}, '{2, 1, -1, -2}, '{1, -1, -1, 1}, '{1, -2, 2, -1}};
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        y[i][j] = 0;
        for (int k = 0; k < 4; k++) begin
          for (int l = 0; l < 4; l++) begin
            y[i][j] += cf[i][k] * x[k][l] * cf[j][l];
          end
        end
      end
    end
  endtask

  task automatic send_rows(input int x [4][4], input int nrows, input int gap_max);
    int gap;
    int waited;
    logic rdy;
    for (int r = 0; r < nrows; r++) begin
      gap = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) in_row[i] = 16'(x[r][i]);
      waited = 0;
      while (1) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        if (rdy) break;
        waited++;
        if (waited > 1000) begin
          check("in_accept_timeout", 1, 0);
          break;
        end
      end
      if (r == 3) check("latency_out_valid", out_valid, 1);
      else        check("load_out_valid_low", out_valid, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: sample at the falling edge, pop on each transfer
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        check("in_ready_in_drain", in_ready, 0);
        if (held_v) check("stall_stable", act_row(), held);
        if (out_ready) begin
          held_v = 1'b0;
          rows_seen++;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_row: got %0h required no row", act_row());
          end else begin
            check("row", act_row(), exp_q.pop_front());
          end
        end else begin
          held_v = 1'b1;
          held   = act_row();
        end
      end else begin
        held_v = 1'b0;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  // Random downstream backpressure for the soak phase
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int x [4][4];
    int e [4][4];
    int imp_x [4][4];
    int imp_e [4][4];
    int ramp_x [4][4];
    int ramp_e [4][4];
    int base;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_row[i] = '0;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_row", act_row(), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    imp_x  = '{'{5, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    imp_e  = '{'{5, 10, 5, 5}, '{10, 20, 10, 10}, '{5, 10, 5, 5}, '{5, 10, 5, 5}};
    ramp_x = '{'{1, 2, 3, 4}, '{1, 2, 3, 4}, '{1, 2, 3, 4}, '{1, 2, 3, 4}};
    ramp_e = '{'{40, -28, 0, -4}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};

    // Zero block
    x = '{default: 0};
    e = '{default: 0};
    push_exp(e);
    send_rows(x, 4, 0);
    drain_wait();

    // Impulse
    push_exp(imp_e);
    send_rows(imp_x, 4, 0);
    drain_wait();

    // DC extreme
    x = '{default: -32768};
    e = '{'{-524288, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
    push_exp(e);
    send_rows(x, 4, 0);
    drain_wait();

    // Constant ramp rows
    push_exp(ramp_e);
    send_rows(ramp_x, 4, 0);
    drain_wait();

    // Positive extreme at X[1][1]
    x = '{default: 0};
    x[1][1] = 32767;
    e = '{'{32767, 32767, -32767, -65534}, '{32767, 32767, -32767, -65534},
          '{-32767, -32767, 32767, 65534}, '{-65534, -65534, 65534, 131068}};
    push_exp(e);
    send_rows(x, 4, 0);
    drain_wait();

    // Backpressure during row 1, with the next block pressing in_valid meanwhile
    push_exp(ramp_e);
    push_exp(imp_e);
    base = rows_seen;
    fork
      begin
        send_rows(ramp_x, 4, 0);
        send_rows(imp_x, 4, 0);
      end
      begin
        wait (rows_seen == base + 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain_wait();

    // Reset after two rows, then a clean impulse block
    send_rows(ramp_x, 2, 0);
    rst_n = 1'b0;
    #1;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_row", act_row(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_exp(imp_e);
    send_rows(imp_x, 4, 0);
    drain_wait();

    // Random blocks with input gaps and output stalls
    rnd_ready = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          case ($urandom_range(0, 7))
            0:       x[r][c] = -32768;
            1:       x[r][c] = 32767;
            default: x[r][c] = int'($signed(16'($urandom)));
          endcase
        end
      end
      model(x, e);
      push_exp(e);
      send_rows(x, 4, 2);
    end
    drain_wait();
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
